vga_sync_gen: RTL and testbench

- Generates VGA raster timing and the scan position (hsp, vsp) that the sprite/overlap blocks (ball, paddles, score) consume.
- Default mode is 640x480@60 from a 25 MHz pixel rate. Counters are free-running; sync pulses are derived from the counters.
- Sits at the top level between the board clock and the VGA DAC/colour mux. Every drawable object compares against hsp/vsp from this block.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_sync_gen_if.sv | 29 ++
 rtl/vga_axis_counter.sv | 61 ++++++
 rtl/vga_sync_gen.sv | 121 ++++++++++++
 tb/tb_vga_sync_gen.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA raster timing for 640x480@60 (25 MHz pixel rate).
// Holds the eight porch/sync/visible constants, the derived line and frame
// totals and the 10-bit coordinate type. The sync generator and every
// drawable object (ball, paddles, score) import this for screen bounds.
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster timing bundle driven by vga_sync_gen.
//   hsp, vsp     scan position
//   hsync, vsync sync pulses (polarity set by the generator)
//   video_on     inside the visible area
//   pix_tick     strobe for cycles in which the counters advanced
//   line_start   first cycle showing hsp == 0
//   frame_start  first cycle showing hsp == 0 and vsp == 0
// Modports: master (the generator), slave (consumers).
interface vga_sync_gen_if;
  import vga_pkg::*;

  coord_t hsp;
  coord_t vsp;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   pix_tick;
  logic   line_start;
  logic   frame_start;

  modport master (
    output hsp, vsp, hsync, vsync, video_on, pix_tick, line_start, frame_start
  );

  modport slave (
    input hsp, vsp, hsync, vsync, video_on, pix_tick, line_start, frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   en        advance request for this cycle
//   wrap_in   carry from the faster axis (tie high for the horizontal axis)
//   pos       registered position, 0..TOTAL-1
//   sync      registered sync, active level SYNC_POL
//   visible   registered, high when pos < VISIBLE
//   wrap_out  combinational: this cycle advances pos from TOTAL-1 to 0
// sync and visible are computed from the next-state position so they always
// line up with the pos value being presented.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   VISIBLE  = 640,
  parameter int   FRONT    = 16,
  parameter int   SYNC     = 96,
  parameter int   BACK     = 48,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   wrap_in,
  output coord_t pos,
  output logic   sync,
  output logic   visible,
  output logic   wrap_out
);

  localparam int     TOTAL   = VISIBLE + FRONT + SYNC + BACK;
  localparam int     SYNC_LO = VISIBLE + FRONT;
  localparam int     SYNC_HI = VISIBLE + FRONT + SYNC;
  localparam coord_t LAST    = coord_t'(TOTAL - 1);

  logic   advance;
  coord_t pos_nxt;

  always_comb begin
    advance  = en & wrap_in;
    wrap_out = advance && (pos == LAST);
    pos_nxt  = pos;
    if (advance) begin
      pos_nxt = (pos == LAST) ? '0 : pos + coord_t'(1);
    end
  end

  // Decode in int so a sync window ending exactly at 1024 cannot overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos     <= '0;
      sync    <= ~SYNC_POL;
      visible <= 1'b1;
    end else begin
      pos     <= pos_nxt;
      sync    <= (int'(pos_nxt) >= SYNC_LO && int'(pos_nxt) < SYNC_HI) ? SYNC_POL : ~SYNC_POL;
      visible <= int'(pos_nxt) < VISIBLE;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA raster timing generator.
// Ports:
//   clk  pixel clock, or 2x pixel clock with the divider enabled
//   rst  synchronous, active-high reset
//   vga  vga_sync_gen_if.master: hsp, vsp, hsync, vsync, video_on,
//        pix_tick, line_start, frame_start (all registered)
// Optional feature macro: VGA_SYNC_PIXDIV_EN -- when defined, a phase toggle
// divides clk by 2 and the counters advance every other cycle (50 MHz board
// clock). When undefined the counters advance every cycle after reset.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int   H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int   H_FRONT   = vga_pkg::H_FRONT,
  parameter int   H_SYNC    = vga_pkg::H_SYNC,
  parameter int   H_BACK    = vga_pkg::H_BACK,
  parameter int   V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int   V_FRONT   = vga_pkg::V_FRONT,
  parameter int   V_SYNC    = vga_pkg::V_SYNC,
  parameter int   V_BACK    = vga_pkg::V_BACK,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  vga_sync_gen_if.master  vga
);

  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Positions are 10 bits wide; larger rasters cannot be represented.
  if (H_TOT > 1024) begin : g_h_total_too_big
    $error("vga_sync_gen: horizontal total exceeds 1024");
  end
  if (V_TOT > 1024) begin : g_v_total_too_big
    $error("vga_sync_gen: vertical total exceeds 1024");
  end

  logic   tick_nxt;
  logic   h_wrap, v_wrap;
  logic   h_sync, v_sync;
  logic   h_vis, v_vis;
  coord_t hsp, vsp;
  logic   pix_tick, line_start, frame_start;

`ifdef VGA_SYNC_PIXDIV_EN
  // Phase is 0 in the first cycle after reset, so the first advance happens
  // on the second clock edge after reset is released.
  logic phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= 1'b0;
    end else begin
      phase <= ~phase;
    end
  end

  assign tick_nxt = phase & ~rst;
`else
  assign tick_nxt = ~rst;
`endif

  vga_axis_counter #(
    .VISIBLE  (H_VISIBLE),
    .FRONT    (H_FRONT),
    .SYNC     (H_SYNC),
    .BACK     (H_BACK),
    .SYNC_POL (SYNC_POL)
  ) u_h (
    .clk      (clk),
    .rst      (rst),
    .en       (tick_nxt),
    .wrap_in  (1'b1),
    .pos      (hsp),
    .sync     (h_sync),
    .visible  (h_vis),
    .wrap_out (h_wrap)
  );

  vga_axis_counter #(
    .VISIBLE  (V_VISIBLE),
    .FRONT    (V_FRONT),
    .SYNC     (V_SYNC),
    .BACK     (V_BACK),
    .SYNC_POL (SYNC_POL)
  ) u_v (
    .clk      (clk),
    .rst      (rst),
    .en       (tick_nxt & h_wrap),
    .wrap_in  (h_wrap),
    .pos      (vsp),
    .sync     (v_sync),
    .visible  (v_vis),
    .wrap_out (v_wrap)
  );

  // Strobes are registered alongside the counters, so they mark the cycle in
  // which the new position first appears and are low between advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_tick    <= tick_nxt;
      line_start  <= h_wrap;
      frame_start <= h_wrap & v_wrap;
    end
  end

  assign vga.hsp         = hsp;
  assign vga.vsp         = vsp;
  assign vga.hsync       = h_sync;
  assign vga.vsync       = v_sync;
  assign vga.video_on    = h_vis & v_vis;
  assign vga.pix_tick    = pix_tick;
  assign vga.line_start  = line_start;
  assign vga.frame_start = frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: bench for vga_sync_gen.
// Two generators share the clock: one with the default 640x480 timing and
// active-low sync, one with a tiny raster (16x11) and active-high sync so
// whole frames and mid-frame resets fit in a short run. Every cycle both are
// compared against a reference computed from the number of pixel advances
// since reset (position = advances mod line length, etc.).
module tb_vga_sync_gen;
  import vga_pkg::*;

  localparam int   SH_V = 8, SH_F = 2, SH_S = 3, SH_B = 3;
  localparam int   SV_V = 6, SV_F = 1, SV_S = 2, SV_B = 2;
  localparam int   SH_T = SH_V + SH_F + SH_S + SH_B;
  localparam int   SV_T = SV_V + SV_F + SV_S + SV_B;
  localparam logic S_POL = 1'b1;
`ifdef VGA_SYNC_PIXDIV_EN
  localparam bit DIV = 1'b1;
`else
  localparam bit DIV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_d = 1'b1;
  logic rst_s = 1'b1;
  int   c_d = 0;
  int   c_s = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // Clock edges since the last edge that saw reset.
  always @(posedge clk) begin
    c_d <= rst_d ? 0 : c_d + 1;
    c_s <= rst_s ? 0 : c_s + 1;
  end

  vga_sync_gen_if vd ();
  vga_sync_gen_if vs ();

  vga_sync_gen dut_d (
    .clk (clk),
    .rst (rst_d),
    .vga (vd)
  );

  vga_sync_gen #(
    .H_VISIBLE (SH_V), .H_FRONT (SH_F), .H_SYNC (SH_S), .H_BACK (SH_B),
    .V_VISIBLE (SV_V), .V_FRONT (SV_F), .V_SYNC (SV_S), .V_BACK (SV_B),
    .SYNC_POL  (S_POL)
  ) dut_s (
    .clk (clk),
    .rst (rst_s),
    .vga (vs)
  );

  // {hsp, vsp, hsync, vsync, video_on, pix_tick, line_start, frame_start}
  logic [25:0] vec_d, vec_s;
  assign vec_d = {vd.hsp, vd.vsp, vd.hsync, vd.vsync, vd.video_on, vd.pix_tick, vd.line_start, vd.frame_start};
  assign vec_s = {vs.hsp, vs.vsp, vs.hsync, vs.vsync, vs.video_on, vs.pix_tick, vs.line_start, vs.frame_start};

  function automatic int ticks(int c);
    return DIV ? c / 2 : c;
  endfunction

  function automatic logic [25:0] model(int c, int hv, int hf, int hs, int hb,
                                        int vv, int vf, int vs_, int vb, logic pol);
    int n, ht, vt, h, v;
    logic tick, hsy, vsy, von, ls, fs;
    n    = ticks(c);
    tick = DIV ? (c >= 2 && c % 2 == 0) : (c >= 1);
    ht   = hv + hf + hs + hb;
    vt   = vv + vf + vs_ + vb;
    h    = n % ht;
    v    = (n / ht) % vt;
    hsy  = (h >= hv + hf && h < hv + hf + hs) ? pol : ~pol;
    vsy  = (v >= vv + vf && v < vv + vf + vs_) ? pol : ~pol;
    von  = (h < hv) && (v < vv);
    ls   = tick && (h == 0);
    fs   = ls && (v == 0);
    return {10'(h), 10'(v), hsy, vsy, von, tick, ls, fs};
  endfunction

  function automatic logic [25:0] exp_d();
    return model(c_d, H_VISIBLE, H_FRONT, H_SYNC, H_BACK, V_VISIBLE, V_FRONT, V_SYNC, V_BACK, 1'b0);
  endfunction

  function automatic logic [25:0] exp_s();
    return model(c_s, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B, S_POL);
  endfunction

  task automatic chk(string tag, logic [25:0] got, logic [25:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_i(string tag, int got, int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    chk("d_cycle", vec_d, exp_d());
    chk("s_cycle", vec_s, exp_s());
  endtask

  initial begin
    logic [25:0] m;
    int n;
    int hsync_cnt, voff_cnt, ls_cnt, fs_cnt, vsync_cnt;
    bit found;
    hsync_cnt = 0; voff_cnt = 0; ls_cnt = 0; fs_cnt = 0; vsync_cnt = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_d", vec_d, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("rst_s", vec_s, {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});

    rst_d = 1'b0;
    rst_s = 1'b0;
    repeat (5) step();
    chk_i("hsp_after_5clk", int'(vd.hsp), DIV ? 2 : 5);

    // Two-plus lines on the default raster, several frames on the small one
    for (int i = 0; i < 4000; i++) begin
      step();
      m = exp_d();
      n = ticks(c_d);
      if (m[2] && n >= 1 && n <= H_TOTAL) begin
        if (vd.hsync == 1'b0) hsync_cnt++;
        if (vd.video_on == 1'b0) voff_cnt++;
      end
      if (m[2] && vd.line_start) ls_cnt++;
      if (m[2] && n == H_TOTAL) begin
        chk_i("wrap_hsp", int'(vd.hsp), 0);
        chk_i("wrap_vsp", int'(vd.vsp), 1);
        chk_i("wrap_line_start", int'(vd.line_start), 1);
      end
      m = exp_s();
      n = ticks(c_s);
      if (m[2] && vs.frame_start) fs_cnt++;
      if (m[2] && n >= 1 && n <= SH_T * SV_T && vs.vsync == S_POL) vsync_cnt++;
      if (ticks(c_d) >= 1700) break;
    end
    chk_i("run_reached_1700_ticks", int'(ticks(c_d) >= 1700), 1);
    chk_i("hsync_active_ticks", hsync_cnt, H_SYNC);
    chk_i("video_off_ticks", voff_cnt, H_TOTAL - H_VISIBLE);
    chk_i("line_start_pulses", ls_cnt, 2);
    chk_i("frame_start_pulses", fs_cnt, 1700 / (SH_T * SV_T));
    chk_i("vsync_active_ticks", vsync_cnt, SV_S * SH_T);

    // Reset while inside both sync pulses of the small raster
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step();
      n = ticks(c_s);
      if (n % SH_T == 11 && (n / SH_T) % SV_T == 8) begin
        found = 1'b1;
        break;
      end
    end
    chk_i("found_sync_point", int'(found), 1);
    chk_i("in_hsync", int'(vs.hsync), int'(S_POL));
    chk_i("in_vsync", int'(vs.vsync), int'(S_POL));
    rst_s = 1'b1;
    step();
    chk("mid_rst_s", vec_s, {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    rst_s = 1'b0;
    repeat (3) step();
    chk_i("resume_hsp", int'(vs.hsp), DIV ? 1 : 3);

    // Random mid-frame resets on both generators
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(20, 400)) step();
      rst_s = 1'b1;
      if (k == 2) rst_d = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      rst_s = 1'b0;
      rst_d = 1'b0;
    end
    repeat (200) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
